// File: rtl/netlist_sweep_controller_pkg.sv
// Shared types and defaults for the netlist sweep controller.
//   state_t        : sweep FSM states
//   MODE_EXH/LFSR  : values of the mode input
//   DEF_*          : default signature polynomial/seed and pattern LFSR taps
package netlist_test_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam logic MODE_EXH  = 1'b0;
   localparam logic MODE_LFSR = 1'b1;

   localparam logic [15:0] DEF_SIG_POLY  = 16'h1021;
   localparam logic [15:0] DEF_SIG_SEED  = 16'hFFFF;
   localparam logic [15:0] DEF_LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/netlist_sweep_controller_if.sv
// Host-side control/status bundle of the sweep controller.
//   master : test host (drives start/mode/pat_count/seed/abort)
//   slave  : controller (drives busy/done/signature/ones_count)
interface netlist_sweep_controller_if #(
   parameter int WIDTH = 16,
   parameter int SIG_W = 16
);
   import netlist_test_pkg::*;

   logic             start;
   logic             mode;
   logic [WIDTH:0]   pat_count;
   logic [WIDTH-1:0] seed;
   logic             abort;
   logic             busy;
   logic             done;
   logic [SIG_W-1:0] signature;
   logic [WIDTH:0]   ones_count;

   modport master (
      output start, mode, pat_count, seed, abort,
      input  busy, done, signature, ones_count
   );

   modport slave (
      input  start, mode, pat_count, seed, abort,
      output busy, done, signature, ones_count
   );

endinterface

// File: rtl/sig_compactor.sv
// Serial single-input signature register (CRC-style MISR).
//   clk, rst_n : clock, async active-low reset (resets to SIG_SEED)
//   load       : reload SIG_SEED (takes priority over en)
//   en         : shift in din this cycle
//   din        : response bit
//   sig        : current signature
module sig_compactor
   import netlist_test_pkg::*;
#(
   parameter int               SIG_W    = 16,
   parameter logic [SIG_W-1:0] SIG_POLY = SIG_W'(DEF_SIG_POLY),
   parameter logic [SIG_W-1:0] SIG_SEED = SIG_W'(DEF_SIG_SEED)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             en,
   input  logic             din,
   output logic [SIG_W-1:0] sig
);

   logic fb;
   assign fb = sig[SIG_W-1] ^ din;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sig <= SIG_SEED;
      end else if (load) begin
         sig <= SIG_SEED;
      end else if (en) begin
         sig <= {sig[SIG_W-2:0], 1'b0} ^ (fb ? SIG_POLY : '0);
      end
   end

endmodule

// File: rtl/netlist_sweep_controller.sv
// Drives patterns into a combinational netlist and compacts its response.
//   clk, rst_n : clock, async active-low reset
//   host       : control/status interface (slave side)
//   dut_a      : pattern to netlist input
//   dut_b      : netlist output, sampled only on SAMPLE edges
//   sample     : high in the cycle whose closing edge samples dut_b
//
// state     | meaning
// ST_IDLE   | waiting for start, busy=0
// ST_SETTLE | pattern applied, waiting SETTLE cycles for the netlist to settle
// ST_SAMPLE | dut_b captured at the closing edge, pattern advances
// ST_DONE   | run complete, done held until the next start
module netlist_sweep_controller
   import netlist_test_pkg::*;
#(
   parameter int               WIDTH     = 16,
   parameter int               SETTLE    = 2,
   parameter int               SIG_W     = 16,
   parameter logic [SIG_W-1:0] SIG_POLY  = SIG_W'(DEF_SIG_POLY),
   parameter logic [SIG_W-1:0] SIG_SEED  = SIG_W'(DEF_SIG_SEED),
   parameter logic [WIDTH-1:0] LFSR_TAPS = WIDTH'(DEF_LFSR_TAPS)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   netlist_sweep_controller_if.slave    host,
   output logic [WIDTH-1:0]             dut_a,
   input  logic                         dut_b,
   output logic                         sample
);

   localparam int             CNT_W       = $clog2(SETTLE + 2);
   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'((SETTLE > 0) ? SETTLE - 1 : 0);
   localparam logic [WIDTH:0] FULL_SWEEP  = {1'b1, {WIDTH{1'b0}}};

   state_t           state;
   logic             run_mode;
   logic [WIDTH:0]   target;
   logic [WIDTH:0]   pat_idx;
   logic [CNT_W-1:0] settle_cnt;
   logic [WIDTH:0]   ones_count;
   logic             busy;
   logic             done;
   logic             accept;
   logic             shift_en;
   logic             last_pat;
   logic [WIDTH-1:0] next_pat;
   logic [SIG_W-1:0] signature;

   assign accept   = host.start && (state == ST_IDLE || state == ST_DONE);
   assign shift_en = (state == ST_SAMPLE) && !host.abort;
   assign last_pat = (pat_idx + (WIDTH+1)'(1)) == target;
   assign next_pat = (run_mode == MODE_LFSR)
                     ? ((dut_a >> 1) ^ (dut_a[0] ? LFSR_TAPS : '0))
                     : dut_a + WIDTH'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         run_mode   <= MODE_EXH;
         target     <= '0;
         pat_idx    <= '0;
         settle_cnt <= '0;
         ones_count <= '0;
         dut_a      <= '0;
         sample     <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (accept) begin
                  run_mode   <= host.mode;
                  target     <= (host.pat_count == '0) ? FULL_SWEEP : host.pat_count;
                  pat_idx    <= '0;
                  ones_count <= '0;
                  done       <= 1'b0;
                  busy       <= 1'b1;
                  settle_cnt <= SETTLE_LOAD;
                  // a zero seed would lock the LFSR at zero
                  if (host.mode == MODE_LFSR)
                     dut_a <= (host.seed == '0) ? WIDTH'(1) : host.seed;
                  else
                     dut_a <= '0;
                  if (SETTLE > 0) begin
                     state  <= ST_SETTLE;
                     sample <= 1'b0;
                  end else begin
                     state  <= ST_SAMPLE;
                     sample <= 1'b1;
                  end
               end
            end
            ST_SETTLE: begin
               if (host.abort) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end else if (settle_cnt == '0) begin
                  state  <= ST_SAMPLE;
                  sample <= 1'b1;
               end else begin
                  settle_cnt <= settle_cnt - CNT_W'(1);
               end
            end
            ST_SAMPLE: begin
               if (host.abort) begin
                  state  <= ST_IDLE;
                  busy   <= 1'b0;
                  sample <= 1'b0;
               end else begin
                  ones_count <= ones_count + (WIDTH+1)'(dut_b);
                  pat_idx    <= pat_idx + (WIDTH+1)'(1);
                  if (last_pat) begin
                     state  <= ST_DONE;
                     done   <= 1'b1;
                     busy   <= 1'b0;
                     sample <= 1'b0;
                  end else begin
                     dut_a <= next_pat;
                     if (SETTLE > 0) begin
                        state      <= ST_SETTLE;
                        sample     <= 1'b0;
                        settle_cnt <= SETTLE_LOAD;
                     end
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   sig_compactor #(
      .SIG_W    (SIG_W),
      .SIG_POLY (SIG_POLY),
      .SIG_SEED (SIG_SEED)
   ) u_sig (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (accept),
      .en    (shift_en),
      .din   (dut_b),
      .sig   (signature)
   );

   assign host.busy       = busy;
   assign host.done       = done;
   assign host.signature  = signature;
   assign host.ones_count = ones_count;

endmodule

// File: tb/tb_netlist_sweep_controller.sv
module tb_netlist_sweep_controller;

   logic        clk;
   logic        rst_n;
   logic [15:0] a_dut_a, b_dut_a;
   logic        a_dut_b, b_dut_b;
   logic        a_sample, b_sample;
   logic        b_use_booth;
   int          checks;
   int          errors;

   netlist_sweep_controller_if #(.WIDTH(16), .SIG_W(16)) if_a ();
   netlist_sweep_controller_if #(.WIDTH(16), .SIG_W(16)) if_b ();

   // instance A settles 2 cycles per pattern, instance B samples every cycle
   netlist_sweep_controller #(.WIDTH(16), .SETTLE(2)) u_dut_a (
      .clk    (clk),
      .rst_n  (rst_n),
      .host   (if_a.slave),
      .dut_a  (a_dut_a),
      .dut_b  (a_dut_b),
      .sample (a_sample)
   );

   netlist_sweep_controller #(.WIDTH(16), .SETTLE(0)) u_dut_b (
      .clk    (clk),
      .rst_n  (rst_n),
      .host   (if_b.slave),
      .dut_a  (b_dut_a),
      .dut_b  (b_dut_b),
      .sample (b_sample)
   );

   // radix-4 Booth digit "negative" flags, xor-reduced to one output bit
   function automatic logic booth_b(input logic [15:0] a);
      logic [16:0] ax;
      logic        r;
      ax = {a, 1'b0};
      r  = 1'b0;
      for (int k = 0; k < 8; k++)
         r = r ^ (ax[2*k+2] & ~(ax[2*k+1] & ax[2*k]));
      return r;
   endfunction

   assign a_dut_b = a_dut_a[0];
   assign b_dut_b = b_use_booth ? booth_b(b_dut_a) : b_dut_a[0];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      checks++; if (if_a.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", if_a.busy); end
      checks++; if (if_a.done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", if_a.done); end
      checks++; if (a_sample !== 1'b0) begin errors++; $display("FAIL rst_sample got %b want 0", a_sample); end
      checks++; if (a_dut_a !== 16'h0000) begin errors++; $display("FAIL rst_dut_a got %h want 0000", a_dut_a); end
      checks++; if (if_a.signature !== 16'hFFFF) begin errors++; $display("FAIL rst_sig got %h want ffff", if_a.signature); end
      checks++; if (if_a.ones_count !== 17'd0) begin errors++; $display("FAIL rst_ones got %0d want 0", if_a.ones_count); end
   endtask

   // exhaustive sweep, 4 patterns, response = a[0]
   task automatic test_exhaustive();
      if_a.mode = 1'b0; if_a.pat_count = 17'd4; if_a.seed = 16'h0; if_a.start = 1'b1;
      @(negedge clk);
      if_a.start = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         if (k > 1) @(negedge clk);
         checks++; if (a_dut_a !== 16'((k-1)/3)) begin errors++; $display("FAIL exh_dut_a k=%0d got %h want %h", k, a_dut_a, 16'((k-1)/3)); end
         checks++; if (a_sample !== ((k-1)%3 == 2)) begin errors++; $display("FAIL exh_sample k=%0d got %b want %b", k, a_sample, ((k-1)%3 == 2)); end
         checks++; if (if_a.busy !== 1'b1 || if_a.done !== 1'b0) begin errors++; $display("FAIL exh_busy k=%0d got busy=%b done=%b want 1/0", k, if_a.busy, if_a.done); end
      end
      @(negedge clk);
      checks++; if (if_a.done !== 1'b1 || if_a.busy !== 1'b0) begin errors++; $display("FAIL exh_done got done=%b busy=%b want 1/0", if_a.done, if_a.busy); end
      checks++; if (a_dut_a !== 16'h0003) begin errors++; $display("FAIL exh_last_a got %h want 0003", a_dut_a); end
      checks++; if (if_a.ones_count !== 17'd2) begin errors++; $display("FAIL exh_ones got %0d want 2", if_a.ones_count); end
      checks++; if (if_a.signature !== 16'h5EBA) begin errors++; $display("FAIL exh_sig got %h want 5eba", if_a.signature); end
   endtask

   task automatic test_lfsr();
      logic [15:0] exp_a [4];
      exp_a[0] = 16'h0001; exp_a[1] = 16'hB400; exp_a[2] = 16'h5A00; exp_a[3] = 16'h2D00;
      b_use_booth = 1'b0;
      if_b.mode = 1'b1; if_b.pat_count = 17'd4; if_b.seed = 16'h0001; if_b.start = 1'b1;
      @(negedge clk);
      if_b.start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (k > 0) @(negedge clk);
         checks++; if (b_dut_a !== exp_a[k]) begin errors++; $display("FAIL lfsr_a k=%0d got %h want %h", k, b_dut_a, exp_a[k]); end
         checks++; if (b_sample !== 1'b1 || if_b.busy !== 1'b1) begin errors++; $display("FAIL lfsr_sample k=%0d got sample=%b busy=%b want 1/1", k, b_sample, if_b.busy); end
      end
      @(negedge clk);
      checks++; if (if_b.done !== 1'b1 || if_b.busy !== 1'b0 || b_sample !== 1'b0) begin errors++; $display("FAIL lfsr_done got done=%b busy=%b sample=%b want 1/0/0", if_b.done, if_b.busy, b_sample); end
      checks++; if (b_dut_a !== 16'h2D00) begin errors++; $display("FAIL lfsr_last_a got %h want 2d00", b_dut_a); end
      checks++; if (if_b.ones_count !== 17'd1) begin errors++; $display("FAIL lfsr_ones got %0d want 1", if_b.ones_count); end
   endtask

   task automatic test_lfsr_seed0();
      if_b.mode = 1'b1; if_b.pat_count = 17'd2; if_b.seed = 16'h0000; if_b.start = 1'b1;
      @(negedge clk);
      if_b.start = 1'b0;
      checks++; if (b_dut_a !== 16'h0001) begin errors++; $display("FAIL seed0_first got %h want 0001", b_dut_a); end
      @(negedge clk);
      checks++; if (b_dut_a !== 16'hB400) begin errors++; $display("FAIL seed0_second got %h want b400", b_dut_a); end
      @(negedge clk);
      checks++; if (if_b.done !== 1'b1) begin errors++; $display("FAIL seed0_done got %b want 1", if_b.done); end
   endtask

   task automatic test_full_sweep();
      logic [15:0] g_sig;
      logic [16:0] g_ones;
      logic        bit_b;
      logic        fb;
      int          n;
      g_sig  = 16'hFFFF;
      g_ones = 17'd0;
      for (int i = 0; i < 65536; i++) begin
         bit_b  = booth_b(16'(i));
         fb     = g_sig[15] ^ bit_b;
         g_sig  = {g_sig[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
         g_ones = g_ones + 17'(bit_b);
      end
      b_use_booth = 1'b1;
      if_b.mode = 1'b0; if_b.pat_count = 17'd0; if_b.seed = 16'h0; if_b.start = 1'b1;
      @(negedge clk);
      if_b.start = 1'b0;
      n = 1;
      while (if_b.done !== 1'b1 && n < 70000) begin
         @(negedge clk);
         n++;
      end
      checks++; if (n !== 65537) begin errors++; $display("FAIL full_cycles got %0d want 65537", n); end
      checks++; if (b_dut_a !== 16'hFFFF) begin errors++; $display("FAIL full_last_a got %h want ffff", b_dut_a); end
      checks++; if (if_b.ones_count !== g_ones) begin errors++; $display("FAIL full_ones got %0d want %0d", if_b.ones_count, g_ones); end
      checks++; if (if_b.signature !== g_sig) begin errors++; $display("FAIL full_sig got %h want %h", if_b.signature, g_sig); end
      b_use_booth = 1'b0;
   endtask

   task automatic test_abort();
      if_a.mode = 1'b0; if_a.pat_count = 17'd8; if_a.seed = 16'h0; if_a.start = 1'b1;
      @(negedge clk);
      if_a.start = 1'b0;
      for (int k = 2; k <= 6; k++) begin
         @(negedge clk);
         if (k == 4) begin
            if_a.mode = 1'b1; if_a.seed = 16'h1234; if_a.start = 1'b1;
         end else begin
            if_a.start = 1'b0;
         end
         if (k >= 5) begin
            checks++; if (a_dut_a !== 16'h0001 || if_a.busy !== 1'b1) begin errors++; $display("FAIL busy_start_ignored k=%0d got a=%h busy=%b want 0001/1", k, a_dut_a, if_a.busy); end
         end
      end
      if_a.mode = 1'b0;
      @(negedge clk);
      checks++; if (a_dut_a !== 16'h0002 || a_sample !== 1'b0) begin errors++; $display("FAIL abort_pre got a=%h sample=%b want 0002/0", a_dut_a, a_sample); end
      if_a.abort = 1'b1;
      @(negedge clk);
      if_a.abort = 1'b0;
      checks++; if (if_a.busy !== 1'b0 || if_a.done !== 1'b0) begin errors++; $display("FAIL abort_state got busy=%b done=%b want 0/0", if_a.busy, if_a.done); end
      checks++; if (if_a.ones_count !== 17'd1) begin errors++; $display("FAIL abort_ones got %0d want 1", if_a.ones_count); end
      checks++; if (if_a.signature !== 16'hDFBE) begin errors++; $display("FAIL abort_sig got %h want dfbe", if_a.signature); end
      checks++; if (a_dut_a !== 16'h0002) begin errors++; $display("FAIL abort_dut_a got %h want 0002", a_dut_a); end
      repeat (4) @(negedge clk);
      checks++; if (if_a.busy !== 1'b0 || if_a.done !== 1'b0) begin errors++; $display("FAIL abort_stays_idle got busy=%b done=%b want 0/0", if_a.busy, if_a.done); end
   endtask

   // start+abort together while idle (start wins), then abort on the only SAMPLE edge
   task automatic test_abort_final();
      if_b.mode = 1'b0; if_b.pat_count = 17'd1; if_b.start = 1'b1; if_b.abort = 1'b1;
      @(negedge clk);
      if_b.start = 1'b0;
      checks++; if (if_b.busy !== 1'b1 || b_sample !== 1'b1) begin errors++; $display("FAIL start_over_abort got busy=%b sample=%b want 1/1", if_b.busy, b_sample); end
      @(negedge clk);
      if_b.abort = 1'b0;
      checks++; if (if_b.done !== 1'b0 || if_b.busy !== 1'b0 || b_sample !== 1'b0) begin errors++; $display("FAIL abort_final got done=%b busy=%b sample=%b want 0/0/0", if_b.done, if_b.busy, b_sample); end
      checks++; if (if_b.ones_count !== 17'd0 || if_b.signature !== 16'hFFFF) begin errors++; $display("FAIL abort_final_hold got ones=%0d sig=%h want 0/ffff", if_b.ones_count, if_b.signature); end
   endtask

   task automatic test_reset_mid_run();
      if_a.mode = 1'b0; if_a.pat_count = 17'd4; if_a.start = 1'b1;
      @(negedge clk);
      if_a.start = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (a_dut_a !== 16'h0001 || if_a.signature !== 16'hEFDF) begin errors++; $display("FAIL midrst_pre got a=%h sig=%h want 0001/efdf", a_dut_a, if_a.signature); end
      #1 rst_n = 1'b0;
      #1;
      checks++; if (if_a.busy !== 1'b0 || if_a.done !== 1'b0 || a_sample !== 1'b0) begin errors++; $display("FAIL midrst_ctrl got busy=%b done=%b sample=%b want 0/0/0", if_a.busy, if_a.done, a_sample); end
      checks++; if (a_dut_a !== 16'h0000 || if_a.signature !== 16'hFFFF || if_a.ones_count !== 17'd0) begin errors++; $display("FAIL midrst_data got a=%h sig=%h ones=%0d want 0000/ffff/0", a_dut_a, if_a.signature, if_a.ones_count); end
      #1 rst_n = 1'b1;
      @(negedge clk);
      test_exhaustive();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      b_use_booth = 1'b0;
      if_a.start = 1'b0; if_a.mode = 1'b0; if_a.pat_count = '0; if_a.seed = '0; if_a.abort = 1'b0;
      if_b.start = 1'b0; if_b.mode = 1'b0; if_b.pat_count = '0; if_b.seed = '0; if_b.abort = 1'b0;
      repeat (2) @(negedge clk);
      test_reset();
      rst_n = 1'b1;
      @(negedge clk);
      if_a.abort = 1'b1;
      @(negedge clk);
      if_a.abort = 1'b0;
      test_reset();
      test_exhaustive();
      @(negedge clk);
      test_lfsr();
      @(negedge clk);
      test_lfsr_seed0();
      @(negedge clk);
      test_abort();
      @(negedge clk);
      test_abort_final();
      @(negedge clk);
      test_reset_mid_run();
      @(negedge clk);
      test_full_sweep();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
